// File: rtl/alu_pkg.sv
// Shared definitions for the ALU output formatter: FSM encoding and BCD constants.
package alu_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        PRONTO   = 2'd2
    } estado_t;

    localparam logic [3:0] LIMIAR_BCD   = 4'd5;
    localparam logic [3:0] CORRECAO_BCD = 4'd3;

    localparam int unsigned NUM_DIGITOS = 3;
    localparam int unsigned LARGURA_BCD = 4 * NUM_DIGITOS;

endpackage

// File: rtl/formatador_resultado_corretor_bcd.sv
// Double-dabble nibble correction: adds 3 to a BCD digit that is 5 or more.
module corretor_bcd
    import alu_pkg::*;
(
    input  logic [3:0] digito,
    output logic [3:0] corrigido_c
);

    // Correction applied before the shift so the doubled digit carries correctly.
    always_comb begin
        corrigido_c = digito;
        if (digito >= LIMIAR_BCD) begin
            corrigido_c = digito + CORRECAO_BCD;
        end
    end

endmodule

// File: rtl/formatador_resultado.sv
// Converts a two's-complement ALU result to sign + magnitude and three BCD digits,
// with valid/ready handshakes on both sides.
module formatador_resultado
    import alu_pkg::*;
#(
    parameter int unsigned LARGURA = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               entrada_valida,
    output logic               entrada_pronta,
    input  logic [LARGURA-1:0] resultado,
    output logic               saida_valida,
    input  logic               saida_aceita,
    output logic               sinal,
    output logic [LARGURA-1:0] magnitude,
    output logic               zero,
    output logic [3:0]         centenas,
    output logic [3:0]         dezenas,
    output logic [3:0]         unidades
);

    localparam int unsigned LARGURA_REG  = LARGURA_BCD + LARGURA;
    localparam int unsigned LARGURA_CONT = $clog2(LARGURA + 1);

    estado_t estado;
    estado_t estado_next;

    logic [LARGURA_REG-1:0]  deslocador;
    logic [LARGURA_REG-1:0]  corrigido;
    logic [LARGURA_REG-1:0]  deslocado;
    logic [LARGURA_CONT-1:0] contador;

    logic               carregar;
    logic               passo;
    logic               concluir;
    logic               sinal_next;
    logic [LARGURA-1:0] magnitude_next;

    // One corrector per BCD digit sitting above the binary part of the shift register.
    for (genvar i = 0; i < NUM_DIGITOS; i++) begin : g_corretor
        corretor_bcd u_corretor (
            .digito      (deslocador[LARGURA + 4*i +: 4]),
            .corrigido_c (corrigido[LARGURA + 4*i +: 4])
        );
    end

    assign corrigido[LARGURA-1:0] = deslocador[LARGURA-1:0];
    assign deslocado              = {corrigido[LARGURA_REG-2:0], 1'b0};

    // Sign/magnitude of the incoming result; zero is never reported as negative.
    always_comb begin
        sinal_next     = resultado[LARGURA-1] && (resultado != '0);
        magnitude_next = resultado;
        if (sinal_next) begin
            magnitude_next = (~resultado) + LARGURA'(1);
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        estado_next = estado;
        carregar    = 1'b0;
        passo       = 1'b0;
        concluir    = 1'b0;
        case (estado)
            OCIOSO: begin
                if (entrada_valida) begin
                    carregar    = 1'b1;
                    estado_next = CONVERTE;
                end
            end
            CONVERTE: begin
                passo = 1'b1;
                if (contador == LARGURA_CONT'(1)) begin
                    concluir    = 1'b1;
                    estado_next = PRONTO;
                end
            end
            PRONTO: begin
                if (saida_aceita) begin
                    estado_next = OCIOSO;
                end
            end
            default: begin
                estado_next = OCIOSO;
            end
        endcase
    end

    // State register with registered handshake outputs decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado         <= OCIOSO;
            entrada_pronta <= 1'b1;
            saida_valida   <= 1'b0;
        end else begin
            estado         <= estado_next;
            entrada_pronta <= (estado_next == OCIOSO);
            saida_valida   <= (estado_next == PRONTO);
        end
    end

    // Capture, shift-and-add-3 iteration and final digit registration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sinal      <= 1'b0;
            magnitude  <= '0;
            zero       <= 1'b0;
            centenas   <= 4'd0;
            dezenas    <= 4'd0;
            unidades   <= 4'd0;
            deslocador <= '0;
            contador   <= '0;
        end else if (carregar) begin
            sinal      <= sinal_next;
            magnitude  <= magnitude_next;
            deslocador <= {LARGURA_BCD'(0), magnitude_next};
            contador   <= LARGURA_CONT'(LARGURA);
        end else if (passo) begin
            deslocador <= deslocado;
            contador   <= contador - LARGURA_CONT'(1);
            if (concluir) begin
                centenas <= deslocado[LARGURA + 8 +: 4];
                dezenas  <= deslocado[LARGURA + 4 +: 4];
                unidades <= deslocado[LARGURA     +: 4];
                zero     <= (magnitude == '0);
            end
        end
    end

endmodule

// File: doc/formatador_resultado.md
Name: formatador_resultado

Overview:
- Output-side formatter for the ALU datapath. It is the reverse of the sign-magnitude comparator's input convention.
- It accepts a two's-complement ALU result over a valid/ready handshake and converts it to sign + magnitude, with negative zero never produced.
- It then converts the magnitude to three BCD digits using a sequential shift-and-add-3 (double dabble) engine.
- The result is held behind a valid/ready output handshake for the display / result stage.

Parameters:
- LARGURA, 5, width of the two's-complement input; legal range 2..8, so the magnitude is at most 128 and 3 BCD digits always suffice.

Ports:
- clk  input  1  single clock, all state on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- entrada_valida  input  1  resultado is valid this cycle.
- entrada_pronta  output  1  block can accept (high only in OCIOSO).
- resultado  input  LARGURA  two's-complement ALU result.
- saida_valida  output  1  formatted result is available.
- saida_aceita  input  1  consumer takes the result this cycle.
- sinal  output  1  1 = negative; forced 0 when magnitude is 0.
- magnitude  output  LARGURA  absolute value of resultado (unsigned).
- zero  output  1  magnitude == 0.
- centenas  output  4  BCD hundreds digit.
- dezenas  output  4  BCD tens digit.
- unidades  output  4  BCD units digit.

Behaviour:
- The clock and reset are fixed: one clock, clk; reset rst is asynchronous and active-high.
- Reset values while rst is high: state OCIOSO, entrada_pronta 1, saida_valida 0. sinal, magnitude, zero, centenas, dezenas, unidades and the internal counter and shift register are all 0.
- FSM states:
  - OCIOSO: entrada_pronta=1. If entrada_valida, accept on that edge:
    - register sinal = resultado[MSB] AND (resultado != 0);
    - register magnitude = sinal ? (0 - resultado) zero-extended : resultado;
    - load the shift register with {12'b0, magnitude};
    - set counter = LARGURA;
    - go to CONVERTE.
  - CONVERTE: entrada_pronta=0. Each cycle:
    - for each BCD nibble, if the nibble >= 5, add 3 (correction applied before the shift);
    - shift the whole register left by 1;
    - decrement counter.
    - On the cycle counter==1, register the final nibbles into centenas, dezenas, unidades, set zero, and go to PRONTO.
  - PRONTO: saida_valida=1. All outputs stay stable while saida_aceita=0. On an edge with saida_aceita=1, go to OCIOSO and drop saida_valida.
- Latency: saida_valida rises exactly LARGURA edges after the accepting edge. Throughput is one result per LARGURA+2 cycles minimum.
- Magnitude width rule: magnitude of the most-negative input (-2^(LARGURA-1)) is 2^(LARGURA-1) and must fit in LARGURA bits unsigned, with no overflow flag needed.
- Held values in OCIOSO: sinal, magnitude, zero and digits keep their last values. They are meaningful only while saida_valida=1.
- entrada_valida during CONVERTE or PRONTO is ignored; there is no buffering, and the producer must hold the request until entrada_pronta.
- saida_aceita outside PRONTO is ignored.
- Reset mid-operation: asynchronous clear of everything to reset values in any state. After release the first edge is in OCIOSO, and no partial result is ever flagged valid.
- Digits are BCD-legal (each 0..9) at all times outside CONVERTE.

Decomposition:
- Shared package alu_pkg holds:
  - state encoding OCIOSO=2'd0, CONVERTE=2'd1, PRONTO=2'd2;
  - BCD constants LIMIAR_BCD=4'd5, CORRECAO_BCD=4'd3;
  - NUM_DIGITOS=3.
- One sub-module, corretor_bcd: combinational, 4-bit in, 4-bit out, adds 3 when the input is >= 5. It is instantiated three times inside the datapath.

Test Plan (each line: stimulus -> required response):
- LARGURA=5, resultado=5'b10000 (-16) with entrada_valida for 1 cycle -> saida_valida rises exactly 5 edges after accept; sinal=1, magnitude=16, zero=0, digits 0/1/6.
- resultado=5'b01111 (+15), saida_aceita held 1 -> sinal=0, magnitude=15, digits 0/1/5. saida_valida is high for exactly 1 cycle, and entrada_pronta returns 1 the following cycle.
- resultado=0, then resultado=5'b11111 (-1) -> first: sinal=0, zero=1, digits 0/0/0 (no negative zero). Second: sinal=1, magnitude=1, digits 0/0/1.
- Backpressure: saida_aceita low for 10 cycles in PRONTO while entrada_valida toggles with new values -> outputs unchanged, entrada_pronta=0 throughout, and the new inputs are not taken. Raising saida_aceita returns the FSM to OCIOSO and the next request is accepted.
- Reset mid-conversion: assert rst 2 cycles after accept -> same-cycle (asynchronous) clear, with all outputs 0 and saida_valida never pulsing. After release entrada_pronta=1, and a new request for +7 yields digits 0/0/7.
- LARGURA=8, resultado=8'h80 (-128) and 8'h64 (+100) -> latency 8 edges; first: sinal=1, magnitude=128, digits 1/2/8. Second: sinal=0, digits 1/0/0.
